// File: rtl/ws2812_bit_encoder.sv
// ws2812_bit_encoder
//
// Turns a stream of single data bits into WS2812 single-wire pulses. Each
// accepted bit produces a fixed TBIT-cycle period: T1H cycles high for a 1,
// T0H cycles high for a 0, the remainder low. A latch request inserts a
// TRES-cycle low gap after the current bit so the LED string shows the frame.
//
// Ports:
//   clk        system clock
//   rstn       asynchronous active-low reset
//   bit_in     data bit, sampled when bit_valid & bit_ready
//   bit_valid  bit_in is valid
//   bit_ready  encoder takes bit_in this cycle (decoded from registered state)
//   latch_req  single-cycle request for a reset/latch gap
//   dout       WS2812 data line (registered)
//   busy       not IDLE, or a latch is pending
//   latch_done one-cycle pulse when the latch gap has finished
//
// Build option:
//   WS2812_DOUT_INV_EN  when defined, dout is inverted at the output register
//                       (idle/reset level 1, high phases drive 0) for
//                       inverting level shifters. Timing is unchanged.

module ws2812_bit_encoder #(
    parameter int T0H  = 20,
    parameter int T1H  = 40,
    parameter int TBIT = 62,
    parameter int TRES = 3000,
    parameter int CW   = 12
) (
    input  logic clk,
    input  logic rstn,
    input  logic bit_in,
    input  logic bit_valid,
    output logic bit_ready,
    input  logic latch_req,
    output logic dout,
    output logic busy,
    output logic latch_done
);

`ifdef WS2812_DOUT_INV_EN
    localparam logic DOUT_LO = 1'b1;
`else
    localparam logic DOUT_LO = 1'b0;
`endif
    localparam logic DOUT_HI = ~DOUT_LO;

    localparam logic [CW-1:0] T0H_LAST  = CW'(T0H - 1);
    localparam logic [CW-1:0] T1H_LAST  = CW'(T1H - 1);
    localparam logic [CW-1:0] TBIT_LAST = CW'(TBIT - 1);
    localparam logic [CW-1:0] TRES_LAST = CW'(TRES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        RES  = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            latch_pending_q;
    logic            cur_bit_q;
    logic            dout_q;
    logic            latch_done_q;

    logic [CW-1:0]   thigh_last;
    logic            bit_end;
    logic            accept;
    logic            latch_any;

    always_comb begin
        thigh_last = cur_bit_q ? T1H_LAST : T0H_LAST;
        bit_end    = (state_q == LOW) && (cnt_q == TBIT_LAST);
        // A pending latch holds off new bits at every boundary.
        bit_ready  = ((state_q == IDLE) || bit_end) && !latch_pending_q;
        accept     = bit_valid && bit_ready;
        // A request arriving this very cycle counts as pending.
        latch_any  = latch_pending_q || latch_req;
        busy       = (state_q != IDLE) || latch_pending_q;
    end

    assign dout       = dout_q;
    assign latch_done = latch_done_q;

    // Data bit register: only meaningful while a bit is in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            cur_bit_q <= bit_in;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            latch_pending_q <= 1'b0;
            dout_q          <= DOUT_LO;
            latch_done_q    <= 1'b0;
        end else begin
            latch_done_q <= 1'b0;
            if (latch_req) begin
                latch_pending_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        dout_q  <= DOUT_HI;
                    end else if (latch_any) begin
                        state_q         <= RES;
                        cnt_q           <= '0;
                        latch_pending_q <= 1'b0;
                    end
                end

                HIGH: begin
                    // cnt keeps running into LOW so the bit period is measured
                    // from the start of the high phase.
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == thigh_last) begin
                        state_q <= LOW;
                        dout_q  <= DOUT_LO;
                    end
                end

                LOW: begin
                    if (bit_end) begin
                        if (accept) begin
                            state_q <= HIGH;
                            cnt_q   <= '0;
                            dout_q  <= DOUT_HI;
                        end else if (latch_any) begin
                            state_q         <= RES;
                            cnt_q           <= '0;
                            latch_pending_q <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                RES: begin
                    if (cnt_q == TRES_LAST) begin
                        state_q      <= IDLE;
                        cnt_q        <= '0;
                        latch_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    dout_q  <= DOUT_LO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Self-checking bench for ws2812_bit_encoder. Expected high-phase widths are
// queued when a bit is handed over and compared when the pulse on dout ends.

module tb_ws2812_bit_encoder;

    localparam int T0H  = 20;
    localparam int T1H  = 40;
    localparam int TBIT = 62;
    localparam int TRES = 3000;
    localparam int CW   = 12;

`ifdef WS2812_DOUT_INV_EN
    localparam logic INV = 1'b1;
`else
    localparam logic INV = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;
    logic latch_req;
    logic dout;
    logic busy;
    logic latch_done;

    int errors = 0;
    int checks = 0;

    int sb[$];
    bit chk_period = 1'b0;

    ws2812_bit_encoder #(
        .T0H (T0H),
        .T1H (T1H),
        .TBIT(TBIT),
        .TRES(TRES),
        .CW  (CW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .latch_req (latch_req),
        .dout      (dout),
        .busy      (busy),
        .latch_done(latch_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pulse monitor: measures high widths and, when enabled, rise-to-rise period.
    int  cyc = 0;
    int  hi_cnt = 0;
    int  last_rise = 0;
    bit  have_rise = 1'b0;
    bit  prev_lvl = 1'b0;
    always @(negedge clk) begin
        logic lvl;
        int   exp_w;
        cyc++;
        if (!rstn) begin
            hi_cnt   = 0;
            prev_lvl = 1'b0;
            have_rise = 1'b0;
        end else begin
            lvl = dout ^ INV;
            if (lvl) begin
                if (!prev_lvl) begin
                    if (chk_period && have_rise)
                        check("bit_period", cyc - last_rise, TBIT);
                    have_rise = 1'b1;
                    last_rise = cyc;
                end
                hi_cnt++;
            end else if (prev_lvl) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", hi_cnt, 0);
                end else begin
                    exp_w = sb.pop_front();
                    check("high_width", hi_cnt, exp_w);
                end
                hi_cnt = 0;
            end
            prev_lvl = lvl;
        end
        if (!chk_period) have_rise = 1'b0;
    end

    task automatic wait_ready();
        int n = 0;
        while (!bit_ready && n < TBIT + TRES + 50) begin
            @(negedge clk);
            n++;
        end
        if (!bit_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic single_bit(input logic b, input int exp_hi, input int exp_rdy);
        int n;
        int busy_low;
        wait_ready();
        bit_in    = b;
        bit_valid = 1'b1;
        sb.push_back(exp_hi);
        @(negedge clk);
        bit_valid = 1'b0;
        n = 0;
        busy_low = 0;
        while (!bit_ready && n < TBIT + 10) begin
            if (!busy) busy_low++;
            @(negedge clk);
            n++;
        end
        check("ready_cycle", n, exp_rdy);
        check("busy_hold", busy_low, 0);
    endtask

    task automatic stream(input logic [23:0] data);
        int idx = 0;
        int guard = 0;
        logic [23:0] d;
        d = data;
        wait_ready();
        bit_valid = 1'b1;
        bit_in    = d[23];
        while (idx < 24 && guard < 24 * TBIT + 100) begin
            if (bit_ready) begin
                sb.push_back(bit_in ? T1H : T0H);
                idx++;
            end
            @(negedge clk);
            guard++;
            if (idx < 24) bit_in = d[23 - idx];
            else bit_valid = 1'b0;
        end
        bit_valid = 1'b0;
        check("stream_bits", idx, 24);
        wait_ready();
        @(negedge clk);
    endtask

    typedef struct {
        logic b;
        int   exp_hi;
        int   exp_rdy;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int n, cnt_a, cnt_b, cnt_c, first, second;
        logic rdy1, rdy2;

        vecs[0] = '{1'b1, T1H, TBIT - 1};
        vecs[1] = '{1'b0, T0H, TBIT - 1};
        vecs[2] = '{1'b0, T0H, TBIT - 1};
        vecs[3] = '{1'b1, T1H, TBIT - 1};

        rstn = 1'b1; bit_in = 1'b0; bit_valid = 1'b0; latch_req = 1'b0;
        #1 rstn = 1'b0;
        #2;
        check("rst_dout", dout, INV);
        check("rst_busy", busy, 0);
        check("rst_latch_done", latch_done, 0);
        check("rst_ready", bit_ready, 1);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_dout", dout, INV);

        // Table of single bits, each handed over for exactly one cycle.
        foreach (vecs[i]) single_bit(vecs[i].b, vecs[i].exp_hi, vecs[i].exp_rdy);
        wait_ready();
        repeat (3) @(negedge clk);
        check("idle_busy", busy, 0);

        // Continuous stream: checks every width and every period.
        chk_period = 1'b1;
        stream(24'hE15F10);
        chk_period = 1'b0;

        // Latch requested mid-bit with the next bit already waiting.
        wait_ready();
        bit_in = 1'b1; bit_valid = 1'b1;
        sb.push_back(T1H);
        @(negedge clk);
        n = 0;
        bit_in = 1'b0;
        repeat (10) begin @(negedge clk); n++; end
        latch_req = 1'b1;
        @(negedge clk); n++;
        latch_req = 1'b0;
        check("latch_busy", busy, 1);
        cnt_a = 0; cnt_b = 0;
        while (!latch_done && n < TBIT + TRES + 20) begin
            if (bit_ready) cnt_a++;
            if (n >= T1H && (dout ^ INV)) cnt_b++;
            @(negedge clk); n++;
        end
        check("latch_done_cycle", n, TBIT + TRES);
        check("latch_ready_blocked", cnt_a, 0);
        check("latch_gap_low", cnt_b, 0);
        check("ready_at_done", bit_ready, 1);
        sb.push_back(T0H);
        @(negedge clk);
        bit_valid = 1'b0;
        check("latch_done_single", latch_done, 0);
        check("next_bit_started", dout ^ INV, 1);
        wait_ready();
        @(negedge clk);

        // Latch from IDLE, plus a second request during the gap.
        latch_req = 1'b1;
        @(negedge clk);
        latch_req = 1'b0;
        n = 1;
        check("res_busy", busy, 1);
        check("res_ready", bit_ready, 0);
        cnt_c = 0; first = 0; second = 0; rdy1 = 1'b1; rdy2 = 1'b0;
        while (n < 2 * (TRES + 1) + 20) begin
            latch_req = (n == 100);
            if (latch_done) begin
                cnt_c++;
                if (cnt_c == 1) begin first = n; rdy1 = bit_ready; end
                else begin second = n; rdy2 = bit_ready; end
            end
            @(negedge clk); n++;
        end
        latch_req = 1'b0;
        check("dbl_first_done", first, TRES + 1);
        check("dbl_first_ready", rdy1, 0);
        check("dbl_second_done", second, 2 * TRES + 2);
        check("dbl_second_ready", rdy2, 1);
        check("dbl_done_count", cnt_c, 2);

        // Asynchronous reset in the middle of a high phase.
        wait_ready();
        bit_in = 1'b1; bit_valid = 1'b1;
        sb.push_back(T1H);
        @(negedge clk);
        bit_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_high", dout ^ INV, 1);
        #2 rstn = 1'b0;
        #1 check("rst_async_dout", dout, INV);
        @(negedge clk);
        sb.delete();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", bit_ready, 1);
        @(negedge clk);
        rstn = 1'b1;
        cnt_a = 0;
        repeat (20) begin @(negedge clk); if (latch_done) cnt_a++; end
        check("post_rst_no_done", cnt_a, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_ready", bit_ready, 1);

        // Reset during a latch gap must not produce latch_done.
        latch_req = 1'b1;
        @(negedge clk);
        latch_req = 1'b0;
        repeat (500) @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        cnt_a = 0;
        repeat (TRES + 20) begin @(negedge clk); if (latch_done) cnt_a++; end
        check("res_rst_no_done", cnt_a, 0);
        check("res_rst_busy", busy, 0);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
